logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's combinational two-input gate block.
- Applies one of eight bitwise operations to WIDTH-bit operands.
- Uses valid/ready handshakes on input and output, with a 2-stage pipeline.
- Optional accumulate mode chains each result into the next operation.
- Emits zero/parity flags and a transaction counter.
- Sits between operand producers and any downstream consumer needing registered, back-pressured logic results.

Parameters:
- WIDTH, 8: operand and result width in bits (>=1).
- CNT_W, 16: width of the transaction counter.

Ports:
- clk  input  1  sole clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored when in_acc=1)
- in_op  input  3  operation select
- in_acc  input  1  accumulate: use the accumulator register in place of in_b
- acc_clr  input  1  synchronous clear of the accumulator
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- out_data  output  WIDTH  result
- out_zero  output  1  out_data == 0
- out_parity  output  1  XOR-reduction of out_data
- txn_count  output  CNT_W  count of accepted output beats

Behaviour:
- Reset (async, rst=1): both stage-valid bits = 0, out_valid=0, out_data=0, out_zero=0, out_parity=0, acc_reg=0, txn_count=0. in_ready is combinational and reads 1 once rst deasserts. Reset mid-transfer discards all in-flight beats with no output.
- in_op encoding: 0 AND, 1 OR, 2 NOT (~a, b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS (a). All operations are bitwise over WIDTH bits.
- Stage 1 (S1): registers a, b, op, acc when in_valid && in_ready.
- Stage 2 (S2): at the S1->S2 transfer, computes result = f(op, a, acc ? acc_reg : b) and registers result, zero and parity into the outputs.
- Movement rules:
  - s2_move = !out_valid || out_ready
  - s1_move = !s1_valid || s2_move
  - in_ready = s1_move (combinational)
- Latency: 2 cycles from input handshake to out_valid when there is no back-pressure. Throughput: 1 beat/cycle.
- Stall: while out_valid && !out_ready, out_data, out_zero and out_parity hold stable, and out_valid does not drop.
- out_valid clears only on a handshake with no new S1 beat arriving.
- Accumulator:
  - acc_reg loads the computed result on every S1->S2 transfer, whether or not that beat had acc set.
  - Back-to-back accumulating beats see the immediately preceding result; there is no hazard.
  - acc_clr=1 forces acc_reg=0 at the next edge and overrides a simultaneous load.
  - A beat computing in the same cycle as acc_clr uses the old acc_reg value.
- txn_count increments by 1 on each out_valid && out_ready cycle and wraps modulo 2^CNT_W without a flag.
- in_valid with in_ready=0 is not accepted; the source must hold its values. The block never drops or duplicates beats.

Test Plan:
- Reset, then with out_ready=1 send a=8'hC5, b=8'h3A across ops 0..7. Expect out_data 00, FF, 3A, FF, 00, FF, 00, C5 in order, with out_valid rising 2 cycles after the first handshake. Zero flag = 1 for 00, and parity = 0 for FF.
- Back-pressure: stream 4 beats with out_ready=0. Expect in_ready to drop after 2 beats are held, and out_data frozen at the first result. Raise out_ready and expect all 4 results in order, none lost, txn_count=4.
- Accumulate: acc_clr pulse, then OR with in_acc=1 and a=01, 02, 04, 80. Expect results 01, 03, 07, 87. Then XOR with in_acc=1 and a=87; expect 00 with out_zero=1.
- acc_clr asserted in the same cycle as an accumulating transfer: expect that beat to use the old acc_reg and the next beat to see acc_reg=0.
- Assert rst mid-stream with both stages full. Expect out_valid=0 immediately (asynchronous) and txn_count=0, with no stale result after release.
- With CNT_W=4, complete 17 output handshakes: expect txn_count=1 (wrap).

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with accumulator,
// zero/parity flags and a wrapping transaction counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_parity,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;
  logic             r_s1_acc;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             r_out_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_txn;

  logic             w_s2_move;
  logic             w_s1_move;
  logic             w_xfer;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_result;

  assign w_s2_move = !r_out_valid || out_ready;
  assign w_s1_move = !r_s1_valid || w_s2_move;
  assign w_xfer    = r_s1_valid && w_s2_move;
  assign in_ready  = w_s1_move;

  // Accumulate mode reads the pre-edge accumulator, so a beat computing
  // alongside acc_clr still sees the old value.
  assign w_opb = r_s1_acc ? r_acc : r_s1_b;

  always_comb begin
    w_result = r_s1_a;
    case (r_s1_op)
      OP_AND:  w_result = r_s1_a & w_opb;
      OP_OR:   w_result = r_s1_a | w_opb;
      OP_NOT:  w_result = ~r_s1_a;
      OP_NAND: w_result = ~(r_s1_a & w_opb);
      OP_NOR:  w_result = ~(r_s1_a | w_opb);
      OP_XOR:  w_result = r_s1_a ^ w_opb;
      OP_XNOR: w_result = ~(r_s1_a ^ w_opb);
      default: w_result = r_s1_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= '0;
      r_s1_acc   <= 1'b0;
    end else if (w_s1_move) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_op  <= in_op;
        r_s1_acc <= in_acc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_zero   <= 1'b0;
      r_out_parity <= 1'b0;
    end else if (w_s2_move) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data   <= w_result;
        r_out_zero   <= (w_result == '0);
        r_out_parity <= ^w_result;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_xfer) begin
      r_acc <= w_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txn <= '0;
    end else if (r_out_valid && out_ready) begin
      r_txn <= r_txn + CNT_ONE;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_zero   = r_out_zero;
  assign out_parity = r_out_parity;
  assign txn_count  = r_txn;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed-vector bench for logic_unit_pipe; a second instance with a
// 4-bit counter shares all inputs to exercise counter wrap.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [2:0]  in_op;
  logic        in_acc;
  logic        acc_clr;
  logic        out_ready;

  logic        in_ready, out_valid, out_zero, out_parity;
  logic [7:0]  out_data;
  logic [15:0] txn_count;

  logic        in_ready4, out_valid4, out_zero4, out_parity4;
  logic [7:0]  out_data4;
  logic [3:0]  txn_count4;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp1 [8];
  logic [7:0] exp3 [5];
  logic [7:0] acc_a [5];

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_zero(out_zero), .out_parity(out_parity), .txn_count(txn_count)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc), .acc_clr(acc_clr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_zero(out_zero4), .out_parity(out_parity4), .txn_count(txn_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic acc);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_acc   = acc;
  endtask

  initial begin
    exp1[0] = 8'h00; exp1[1] = 8'hFF; exp1[2] = 8'h3A; exp1[3] = 8'hFF;
    exp1[4] = 8'h00; exp1[5] = 8'hFF; exp1[6] = 8'h00; exp1[7] = 8'hC5;
    acc_a[0] = 8'h01; acc_a[1] = 8'h02; acc_a[2] = 8'h04; acc_a[3] = 8'h80; acc_a[4] = 8'h87;
    exp3[0] = 8'h01; exp3[1] = 8'h03; exp3[2] = 8'h07; exp3[3] = 8'h87; exp3[4] = 8'h00;

    rst = 1'b1;
    acc_clr = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_out_parity", {31'd0, out_parity}, 32'd0);
    chk("rst_txn", {16'd0, txn_count}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // All eight ops streamed back to back
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 8'hC5, 8'h3A, i[2:0], 1'b0);
      else       drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      step();
      if (i == 0) begin
        chk("lat_not_yet_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk($sformatf("op%0d_valid", i-1), {31'd0, out_valid}, 32'd1);
        chk($sformatf("op%0d_data", i-1), {24'd0, out_data}, {24'd0, exp1[i-1]});
        chk($sformatf("op%0d_zero", i-1), {31'd0, out_zero}, {31'd0, exp1[i-1] == 8'h00});
        chk($sformatf("op%0d_parity", i-1), {31'd0, out_parity}, 32'd0);
      end
    end
    step();
    chk("ops_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("ops_txn", {16'd0, txn_count}, 32'd8);

    // Back-pressure: two beats fill the pipe, the rest wait
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 8'h00, 3'd7, 1'b0);
    chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
    step();
    drive(1'b1, 8'h22, 8'h00, 3'd7, 1'b0);
    chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_first_data", {24'd0, out_data}, 32'h11);
    drive(1'b1, 8'h33, 8'h00, 3'd7, 1'b0);
    chk("bp_rdy_drop", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_data", {24'd0, out_data}, 32'h11);
    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_rdy_still0", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_data2", {24'd0, out_data}, 32'h11);
    chk("bp_hold_txn", {16'd0, txn_count}, 32'd8);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_release", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_out1", {24'd0, out_data}, 32'h22);
    drive(1'b1, 8'h44, 8'h00, 3'd7, 1'b0);
    step();
    chk("bp_out2", {24'd0, out_data}, 32'h33);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step();
    chk("bp_out3", {24'd0, out_data}, 32'h44);
    chk("bp_out3_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("bp_drain_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_txn", {16'd0, txn_count}, 32'd12);

    // Accumulate chain: OR into acc, then XOR cancels
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4)       drive(1'b1, acc_a[i], 8'hFF, 3'd1, 1'b1);
      else if (i == 4) drive(1'b1, acc_a[i], 8'hFF, 3'd5, 1'b1);
      else             drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
      step();
      if (i > 0) begin
        chk($sformatf("acc%0d_data", i-1), {24'd0, out_data}, {24'd0, exp3[i-1]});
        chk($sformatf("acc%0d_zero", i-1), {31'd0, out_zero}, {31'd0, exp3[i-1] == 8'h00});
        chk($sformatf("acc%0d_parity", i-1), {31'd0, out_parity}, {31'd0, ^exp3[i-1]});
      end
    end
    step();
    chk("acc_txn", {16'd0, txn_count}, 32'd17);
    chk("wrap_txn4", {28'd0, txn_count4}, 32'd1);
    chk("dut4_data", {24'd0, out_data4}, 32'h00);
    chk("dut4_flags", {30'd0, out_zero4, out_parity4}, 32'd2);
    chk("dut4_hs", {30'd0, in_ready4, out_valid4}, 32'd2);

    // acc_clr coincident with an accumulating transfer
    drive(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0);
    step();
    drive(1'b1, 8'h01, 8'h00, 3'd1, 1'b1);
    step();
    chk("clr_load_5a", {24'd0, out_data}, 32'h5A);
    drive(1'b1, 8'h0F, 8'h00, 3'd1, 1'b1);
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    chk("clr_old_acc", {24'd0, out_data}, 32'h5B);
    step();
    chk("clr_new_acc", {24'd0, out_data}, 32'h0F);
    step();
    chk("clr_txn", {16'd0, txn_count}, 32'd20);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 8'h00, 3'd7, 1'b0);
    step();
    drive(1'b1, 8'hBB, 8'h00, 3'd7, 1'b0);
    step();
    chk("mid_full_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_full_rdy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_txn", {16'd0, txn_count}, 32'd0);
    chk("mid_rst_data", {24'd0, out_data}, 32'd0);
    chk("mid_rst_txn4", {28'd0, txn_count4}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst_nostale%0d", i), {31'd0, out_valid}, 32'd0);
    end
    chk("post_rst_txn", {16'd0, txn_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
